timebase_ultra_chan: RTL and testbench

//  Parametrised timebase for the ultrasonic ranging path. Free-running or one-shot

---
 rtl/timebase_ultra_chan_if.sv | 29 ++
 rtl/timebase_ultra_chan.sv | 107 ++++++++++
 tb/tb_timebase_ultra_chan.sv | 209 ++++++++++++++++++++
 3 files changed

// File: rtl/timebase_ultra_chan_if.sv
// Control and status bundle for the ultrasonic ranging timebase.
// Master drives controls and compare windows; slave is the timebase.
interface timebase_ultra_chan_if #(
    parameter int COUNT_W = 23,
    parameter int N_CH    = 2,
    parameter int CYC_W   = 8
);
    logic                    en;
    logic                    clr;
    logic                    oneshot;
    logic                    start;
    logic [N_CH*COUNT_W-1:0] cmp_start;
    logic [N_CH*COUNT_W-1:0] cmp_stop;
    logic [COUNT_W-1:0]      count;
    logic                    wrap;
    logic [CYC_W-1:0]        cyc_cnt;
    logic                    busy;
    logic [N_CH-1:0]         win;

    modport master (
        output en, clr, oneshot, start, cmp_start, cmp_stop,
        input  count, wrap, cyc_cnt, busy, win
    );

    modport slave (
        input  en, clr, oneshot, start, cmp_start, cmp_stop,
        output count, wrap, cyc_cnt, busy, win
    );
endinterface

// File: rtl/timebase_ultra_chan.sv
// Measurement-cycle timebase: free-running or one-shot counter with
// pause, sync clear, wrap pulse, cycle count and compare windows.
module timebase_ultra_chan #(
    parameter int COUNT_W = 23,
    parameter int PERIOD  = 6_000_000,
    parameter int N_CH    = 2,
    parameter int CYC_W   = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    timebase_ultra_chan_if.slave bus
);
    if (PERIOD < 2 || N_CH < 1 ||
        longint'(PERIOD) > (longint'(1) << COUNT_W)) begin : g_bad_cfg
        $error("timebase_ultra_chan: bad PERIOD/COUNT_W/N_CH");
    end

    localparam logic [COUNT_W-1:0] LAST = COUNT_W'(PERIOD - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t             state, state_n;
    logic [COUNT_W-1:0] count_q, count_n;
    logic               wrap_q, wrap_n;
    logic [CYC_W-1:0]   cyc_q, cyc_n;
    logic [N_CH-1:0]    win_v;
    logic               busy;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state   <= IDLE;
            count_q <= '0;
            wrap_q  <= 1'b0;
            cyc_q   <= '0;
        end else begin
            state   <= state_n;
            count_q <= count_n;
            wrap_q  <= wrap_n;
            cyc_q   <= cyc_n;
        end
    end

    always_comb begin
        state_n = state;
        count_n = count_q;
        wrap_n  = 1'b0;
        cyc_n   = cyc_q;
        if (bus.clr) begin
            state_n = IDLE;
            count_n = '0;
            cyc_n   = '0;
        end else begin
            unique case (state)
                IDLE: begin
                    count_n = '0;
                    if ((!bus.oneshot && bus.en) ||
                        (bus.oneshot && bus.start))
                        state_n = RUN;
                end
                RUN: begin
                    if (bus.en) begin
                        if (count_q == LAST) begin
                            count_n = '0;
                            wrap_n  = 1'b1;
                            cyc_n   = cyc_q + 1'b1;
                            // oneshot only takes effect at the wrap
                            if (bus.oneshot)
                                state_n = DONE;
                        end else begin
                            count_n = count_q + 1'b1;
                        end
                    end
                end
                DONE: begin
                    count_n = '0;
                    if (bus.start || (!bus.oneshot && bus.en))
                        state_n = RUN;
                end
                default: begin
                    state_n = IDLE;
                    count_n = '0;
                end
            endcase
        end
    end

    assign busy = (state == RUN);

    always_comb begin
        win_v = '0;
        for (int i = 0; i < N_CH; i++) begin
            win_v[i] = busy &&
                (bus.cmp_start[i*COUNT_W +: COUNT_W] <= count_q) &&
                (count_q < bus.cmp_stop[i*COUNT_W +: COUNT_W]);
        end
    end

    assign bus.count   = count_q;
    assign bus.wrap    = wrap_q;
    assign bus.cyc_cnt = cyc_q;
    assign bus.busy    = busy;
    assign bus.win     = win_v;
endmodule

// File: tb/tb_timebase_ultra_chan.sv
// Randomised bench for timebase_ultra_chan against an arithmetic
// reference model of the measurement cycle.
module tb_timebase_ultra_chan;
    localparam int CW = 5;
    localparam int P  = 10;
    localparam int NC = 2;
    localparam int YW = 4;

    localparam int S_IDLE = 0;
    localparam int S_RUN  = 1;
    localparam int S_DONE = 2;

    logic clk = 1'b0;
    logic rst = 1'b0;

    timebase_ultra_chan_if #(.COUNT_W(CW), .N_CH(NC), .CYC_W(YW)) bus ();

    timebase_ultra_chan #(
        .COUNT_W(CW), .PERIOD(P), .N_CH(NC), .CYC_W(YW)
    ) dut (
        .clk   (clk),
        .reset (rst),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    int m_state, m_tick, m_cyc, m_wrap;
    int cs [NC];
    int ce [NC];

    task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0d want %0d @%0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_state = S_IDLE;
        m_tick  = 0;
        m_cyc   = 0;
        m_wrap  = 0;
    endtask

    task automatic model_step();
        if (!rst || bus.clr) begin
            model_reset();
        end else begin
            m_wrap = 0;
            if (m_state == S_IDLE) begin
                if ((!bus.oneshot && bus.en) || (bus.oneshot && bus.start))
                    m_state = S_RUN;
            end else if (m_state == S_DONE) begin
                if (bus.start || (!bus.oneshot && bus.en))
                    m_state = S_RUN;
            end else if (bus.en) begin
                m_tick = (m_tick + 1) % P;
                if (m_tick == 0) begin
                    m_wrap = 1;
                    m_cyc  = (m_cyc + 1) % (1 << YW);
                    if (bus.oneshot) m_state = S_DONE;
                end
            end
        end
    endtask

    task automatic apply_cmp();
        for (int i = 0; i < NC; i++) begin
            bus.cmp_start[i*CW +: CW] = CW'(cs[i]);
            bus.cmp_stop[i*CW +: CW]  = CW'(ce[i]);
        end
    endtask

    task automatic compare();
        logic [NC-1:0] ew;
        ew = '0;
        for (int i = 0; i < NC; i++)
            ew[i] = (m_state == S_RUN) && cs[i] <= m_tick && m_tick < ce[i];
        check("count", 32'(bus.count), 32'(m_tick));
        check("wrap", 32'(bus.wrap), 32'(m_wrap));
        check("cyc_cnt", 32'(bus.cyc_cnt), 32'(m_cyc));
        check("busy", 32'(bus.busy), 32'(m_state == S_RUN));
        check("win", 32'(bus.win), 32'(ew));
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        @(negedge clk);
        compare();
    endtask

    task automatic wait_count(int v, string tag);
        int n = 0;
        while (int'(bus.count) != v && n < 3 * P) begin
            tick();
            n++;
        end
        check(tag, 32'(bus.count), 32'(v));
    endtask

    task automatic async_reset();
        #2 rst = 1'b0;
        #1;
        model_reset();
        check("rst_count", 32'(bus.count), 32'd0);
        check("rst_wrap", 32'(bus.wrap), 32'd0);
        check("rst_cyc", 32'(bus.cyc_cnt), 32'd0);
        check("rst_busy", 32'(bus.busy), 32'd0);
        check("rst_win", 32'(bus.win), 32'd0);
        @(negedge clk);
        rst = 1'b1;
    endtask

    initial begin
        bus.en = 1'b0;
        bus.clr = 1'b0;
        bus.oneshot = 1'b0;
        bus.start = 1'b0;
        cs[0] = 2; ce[0] = 5;
        cs[1] = 5; ce[1] = 5;
        apply_cmp();
        model_reset();
        repeat (2) @(negedge clk);
        compare();
        rst = 1'b1;

        // continuous, more than 16 wraps so cyc_cnt rolls over
        bus.en = 1'b1;
        repeat (P * 17 + 3) tick();

        // pause at count 4
        wait_count(4, "pause_at4");
        bus.en = 1'b0;
        repeat (3) tick();
        check("pause_hold", 32'(bus.count), 32'd4);
        check("pause_busy", 32'(bus.busy), 32'd1);
        bus.en = 1'b1;
        repeat (3) tick();

        // windows: second channel beyond end of cycle
        repeat (2 * P) tick();
        cs[1] = 7; ce[1] = 20;
        apply_cmp();
        #1 compare();
        repeat (2 * P) tick();

        // one-shot
        bus.clr = 1'b1;
        tick();
        bus.clr = 1'b0;
        bus.oneshot = 1'b1;
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        repeat (P + 2) tick();
        check("os_busy", 32'(bus.busy), 32'd0);
        check("os_count", 32'(bus.count), 32'd0);
        check("os_cyc1", 32'(bus.cyc_cnt), 32'd1);
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        repeat (P + 2) tick();
        check("os_cyc2", 32'(bus.cyc_cnt), 32'd2);
        bus.oneshot = 1'b0;
        repeat (3) tick();

        // clear at the last tick beats the wrap
        wait_count(P - 1, "clr_at9");
        bus.clr = 1'b1;
        tick();
        check("clr_count", 32'(bus.count), 32'd0);
        check("clr_wrap", 32'(bus.wrap), 32'd0);
        check("clr_cyc", 32'(bus.cyc_cnt), 32'd0);
        check("clr_busy", 32'(bus.busy), 32'd0);
        bus.clr = 1'b0;
        repeat (3) tick();

        // async reset mid-cycle
        wait_count(6, "rst_at6");
        async_reset();
        repeat (P + 3) tick();

        // randomised phase
        for (int k = 0; k < 1500; k++) begin
            bus.en    = ($urandom_range(0, 9) != 0);
            bus.clr   = ($urandom_range(0, 99) == 0);
            bus.start = ($urandom_range(0, 7) == 0);
            if ($urandom_range(0, 29) == 0) bus.oneshot = ~bus.oneshot;
            if ($urandom_range(0, 19) == 0) begin
                for (int i = 0; i < NC; i++) begin
                    cs[i] = $urandom_range(0, 20);
                    ce[i] = $urandom_range(0, 20);
                end
                apply_cmp();
            end
            if ($urandom_range(0, 299) == 0) async_reset();
            tick();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
